regfile_write_sched: RTL and testbench



---
 rtl/regfile_write_sched.sv | 88 ++++++++
 tb/tb_regfile_write_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sched.sv
// rtl/regfile_write_sched.sv - register file write-port scheduler with post-reset clear
// Clears r1..INIT_LAST after reset, then round-robins the write port between requesters A and B.
module regfile_write_sched #(
    parameter int INIT_LAST = 31
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ValidA,
    input  logic [4:0]  RegA,
    input  logic [31:0] DataA,
    output logic        ReadyA,
    input  logic        ValidB,
    input  logic [4:0]  RegB,
    input  logic [31:0] DataB,
    output logic        ReadyB,
    output logic        Busy,
    output logic [31:0] WriteData,
    output logic [4:0]  WriteRegister,
    output logic        RegWrite
);

    typedef enum logic {INIT, RUN} state_t;

    state_t      state, state_nxt;
    logic [4:0]  init_ptr, init_ptr_nxt;
    logic        last_grant, last_grant_nxt;
    logic [31:0] write_data_nxt;
    logic [4:0]  write_register_nxt;
    logic        reg_write_nxt;

    // last_grant = 1 means B won last, so A takes a tie.
    assign Busy   = (state == INIT);
    assign ReadyA = (state == RUN) && ValidA && (!ValidB || last_grant);
    assign ReadyB = (state == RUN) && ValidB && (!ValidA || !last_grant);

    always_comb begin
        state_nxt          = state;
        init_ptr_nxt       = init_ptr;
        last_grant_nxt     = last_grant;
        write_data_nxt     = WriteData;
        write_register_nxt = WriteRegister;
        reg_write_nxt      = 1'b0;
        case (state)
            INIT: begin
                reg_write_nxt      = 1'b1;
                write_register_nxt = init_ptr;
                write_data_nxt     = 32'd0;
                init_ptr_nxt       = init_ptr + 5'd1;
                if (init_ptr == 5'(INIT_LAST))
                    state_nxt = RUN;
            end
            RUN: begin
                // Writes to r0 are consumed but never enabled at the regfile.
                if (ReadyA) begin
                    write_register_nxt = RegA;
                    write_data_nxt     = DataA;
                    reg_write_nxt      = (RegA != 5'd0);
                    last_grant_nxt     = 1'b0;
                end else if (ReadyB) begin
                    write_register_nxt = RegB;
                    write_data_nxt     = DataB;
                    reg_write_nxt      = (RegB != 5'd0);
                    last_grant_nxt     = 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= INIT;
            init_ptr      <= 5'd1;
            last_grant    <= 1'b1;
            RegWrite      <= 1'b0;
            WriteRegister <= 5'd0;
            WriteData     <= 32'd0;
        end else begin
            state         <= state_nxt;
            init_ptr      <= init_ptr_nxt;
            last_grant    <= last_grant_nxt;
            RegWrite      <= reg_write_nxt;
            WriteRegister <= write_register_nxt;
            WriteData     <= write_data_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
// tb/tb_regfile_write_sched.sv - directed, table-driven bench for regfile_write_sched
module tb_regfile_write_sched;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ValidA, ValidB;
    logic [4:0]  RegA, RegB;
    logic [31:0] DataA, DataB;
    logic        ReadyA, ReadyB, Busy;
    logic [31:0] WriteData;
    logic [4:0]  WriteRegister;
    logic        RegWrite;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_write_sched #(.INIT_LAST(31)) dut (
        .Clk(Clk), .Reset(Reset),
        .ValidA(ValidA), .RegA(RegA), .DataA(DataA), .ReadyA(ReadyA),
        .ValidB(ValidB), .RegB(RegB), .DataB(DataB), .ReadyB(ReadyB),
        .Busy(Busy), .WriteData(WriteData), .WriteRegister(WriteRegister),
        .RegWrite(RegWrite)
    );

    always #5 Clk = ~Clk;

    // Register file the scheduler drives; preload port used before reset.
    logic [31:0] rf [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = 5'd0;
    logic [31:0] pre_data = 32'd0;
    logic [4:0]  rd_addr1 = 5'd0, rd_addr2 = 5'd0;
    logic [31:0] rd_data1, rd_data2;

    always @(posedge Clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;
    end
    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'd0 : rf[rd_addr1];
    assign rd_data2 = (rd_addr2 == 5'd0) ? 32'd0 : rf[rd_addr2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_reg(input string name, input logic [4:0] addr, input logic [31:0] exp);
        rd_addr1 = addr;
        rd_addr2 = addr;
        #1;
        check({name, " port1"}, rd_data1, exp);
        check({name, " port2"}, rd_data2, exp);
    endtask

    // Called at the negedge where Reset has just been dropped; returns at the first negedge with Busy low.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!Busy) break;
            n++;
            cycle();
        end
    endtask

    typedef struct {
        logic        va;
        logic [4:0]  ra;
        logic [31:0] da;
        logic        vb;
        logic [4:0]  rb;
        logic [31:0] db;
        logic        exp_ra;
        logic        exp_rb;
        logic        exp_we;
        logic [4:0]  exp_wr;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [11];
    int   nbusy;
    int   ready_in_init;

    initial begin
        // va ra da      vb rb db     rdyA rdyB we wr wd
        vecs[0]  = '{1, 3, 100,  1, 4, 200,   1, 0, 1, 3, 100};
        vecs[1]  = '{1, 3, 100,  1, 4, 200,   0, 1, 1, 4, 200};
        vecs[2]  = '{1, 3, 100,  1, 4, 200,   1, 0, 1, 3, 100};
        vecs[3]  = '{1, 3, 100,  1, 4, 200,   0, 1, 1, 4, 200};
        vecs[4]  = '{1, 2, 42,   0, 0, 0,     1, 0, 1, 2, 42};
        vecs[5]  = '{0, 0, 0,    0, 0, 0,     0, 0, 0, 2, 42};
        vecs[6]  = '{0, 0, 0,    1, 0, 7234,  0, 1, 0, 0, 7234};
        vecs[7]  = '{1, 9, 11,   1, 10, 22,   1, 0, 1, 9, 11};
        vecs[8]  = '{0, 0, 0,    1, 10, 22,   0, 1, 1, 10, 22};
        vecs[9]  = '{1, 0, 5,    0, 0, 0,     1, 0, 0, 0, 5};
        vecs[10] = '{1, 11, 33,  1, 12, 44,   0, 1, 1, 12, 44};

        Reset = 1'b1;
        ValidA = 1'b0; RegA = 5'd0; DataA = 32'd0;
        ValidB = 1'b0; RegB = 5'd0; DataB = 32'd0;
        @(negedge Clk);
        pre_we = 1'b1; pre_addr = 5'd5; pre_data = 32'hDEADBEEF;
        cycle();
        pre_we = 1'b0;
        check("reset RegWrite", 32'(RegWrite), 32'd0);
        check("reset WriteRegister", 32'(WriteRegister), 32'd0);
        check("reset WriteData", WriteData, 32'd0);
        check("reset Busy", 32'(Busy), 32'd1);

        // Init clear
        Reset = 1'b0;
        ValidA = 1'b1; RegA = 5'd1; DataA = 32'd1;
        ValidB = 1'b1; RegB = 5'd1; DataB = 32'd1;
        #1;
        check("init ReadyA", 32'(ReadyA), 32'd0);
        check("init ReadyB", 32'(ReadyB), 32'd0);
        ValidA = 1'b0; ValidB = 1'b0;
        count_busy(nbusy);
        check("init busy cycles", 32'(nbusy), 32'd31);
        cycle();
        check_reg("init r5", 5'd5, 32'd0);
        check_reg("init r31", 5'd31, 32'd0);
        check_reg("init r1", 5'd1, 32'd0);

        // Table: arbitration and write-port outputs
        for (int i = 0; i < 11; i++) begin
            ValidA = vecs[i].va; RegA = vecs[i].ra; DataA = vecs[i].da;
            ValidB = vecs[i].vb; RegB = vecs[i].rb; DataB = vecs[i].db;
            #1;
            check($sformatf("vec%0d ReadyA", i), 32'(ReadyA), 32'(vecs[i].exp_ra));
            check($sformatf("vec%0d ReadyB", i), 32'(ReadyB), 32'(vecs[i].exp_rb));
            cycle();
            check($sformatf("vec%0d RegWrite", i), 32'(RegWrite), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d WriteRegister", i), 32'(WriteRegister), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d WriteData", i), WriteData, vecs[i].exp_wd);
        end
        ValidA = 1'b0; ValidB = 1'b0;
        cycle();
        check("idle RegWrite", 32'(RegWrite), 32'd0);
        check_reg("r2", 5'd2, 32'd42);
        check_reg("r3", 5'd3, 32'd100);
        check_reg("r4", 5'd4, 32'd200);
        check_reg("r0", 5'd0, 32'd0);
        check_reg("r9", 5'd9, 32'd11);
        check_reg("r10", 5'd10, 32'd22);
        check_reg("r12", 5'd12, 32'd44);
        check_reg("r11 untouched", 5'd11, 32'd0);

        // Busy blocking: A held valid through init
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        ValidA = 1'b1; RegA = 5'd6; DataA = 32'd55;
        ready_in_init = 0;
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!Busy) break;
            nbusy++;
            if (ReadyA) ready_in_init++;
            cycle();
        end
        check("blocking busy cycles", 32'(nbusy), 32'd31);
        check("ReadyA during init", 32'(ready_in_init), 32'd0);
        check("ReadyA first RUN cycle", 32'(ReadyA), 32'd1);
        cycle();
        ValidA = 1'b0;
        check("blocking RegWrite", 32'(RegWrite), 32'd1);
        check("blocking WriteRegister", 32'(WriteRegister), 32'd6);
        cycle();
        check_reg("blocking r6", 5'd6, 32'd55);

        // Reset on the same edge as an accepted write
        ValidA = 1'b1; RegA = 5'd7; DataA = 32'd99;
        Reset = 1'b1;
        #1;
        check("midrun ReadyA", 32'(ReadyA), 32'd1);
        cycle();
        ValidA = 1'b0;
        check("midrun RegWrite", 32'(RegWrite), 32'd0);
        check("midrun WriteRegister", 32'(WriteRegister), 32'd0);
        check("midrun WriteData", WriteData, 32'd0);
        Reset = 1'b0;
        count_busy(nbusy);
        check("midrun busy cycles", 32'(nbusy), 32'd31);
        cycle();
        check_reg("midrun r7", 5'd7, 32'd0);
        check_reg("midrun r6 cleared", 5'd6, 32'd0);

        // Reset in the middle of init restarts the sequence
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("restart WriteRegister before", 32'(WriteRegister), 32'd10);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        count_busy(nbusy);
        check("restart busy cycles", 32'(nbusy), 32'd31);
        check("restart last issued", 32'(WriteRegister), 32'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
